// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the 4-bit add/subtract calculator datapath.
// Optional accumulator mode (chain on previous result) is enabled by defining CALC_ACCUM_EN.
`timescale 1ns/1ps
module calc_seq_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       sub_sw,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic [4:0] sum_in,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       sub_out,
  output logic [4:0] result,
  output logic       neg,
  output logic       res_valid,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StLoadA = 2'd0,
    StLoadB = 2'd1,
    StExec  = 2'd2,
    StShow  = 2'd3
  } state_e;

  localparam logic [2:0] SettleInit = 3'(SETTLE_CYC);

  state_e     state_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       sub_q;
  logic [4:0] result_q;
  logic       neg_q;
  logic       res_valid_q;
  logic       done_q;
  logic [2:0] cnt_q;

  // Two synchronizer stages plus one history stage for edge detection.
  logic [2:0] enter_sync_q;
  logic [2:0] clear_sync_q;
  logic       enter_p;
  logic       clear_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_sync_q <= 3'b000;
      clear_sync_q <= 3'b000;
    end else begin
      enter_sync_q <= {enter_sync_q[1:0], key_enter};
      clear_sync_q <= {clear_sync_q[1:0], key_clear};
    end
  end

  assign enter_p = enter_sync_q[1] & ~enter_sync_q[2];
  assign clear_p = clear_sync_q[1] & ~clear_sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoadA;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      sub_q       <= 1'b0;
      result_q    <= 5'd0;
      neg_q       <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= 3'd0;
    end else begin
      done_q <= 1'b0;
      if (clear_p) begin
        // Clear outranks a simultaneous enter, which is simply dropped.
        state_q     <= StLoadA;
        a_q         <= 4'd0;
        b_q         <= 4'd0;
        sub_q       <= 1'b0;
        result_q    <= 5'd0;
        neg_q       <= 1'b0;
        res_valid_q <= 1'b0;
        cnt_q       <= 3'd0;
      end else begin
        case (state_q)
          StLoadA: begin
            if (enter_p) begin
              a_q     <= sw;
              state_q <= StLoadB;
            end
          end
          StLoadB: begin
            if (enter_p) begin
              b_q     <= sw;
              sub_q   <= sub_sw;
              cnt_q   <= SettleInit;
              state_q <= StExec;
            end
          end
          StExec: begin
            if (cnt_q <= 3'd1) begin
              result_q    <= sum_in;
              neg_q       <= sub_q & sum_in[4];
              done_q      <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= StShow;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
          StShow: begin
            if (enter_p) begin
              res_valid_q <= 1'b0;
`ifdef CALC_ACCUM_EN
              a_q         <= result_q[3:0];
              state_q     <= StLoadB;
`else
              state_q     <= StLoadA;
`endif
            end
          end
          default: state_q <= StLoadA;
        endcase
      end
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign sub_out   = sub_q;
  assign result    = result_q;
  assign neg       = neg_q;
  assign res_valid = res_valid_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl with a stand-in adder/subtractor datapath.
`timescale 1ns/1ps
module tb_calc_seq_ctrl;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       sub_sw;
  logic       key_enter;
  logic       key_clear;
  logic [4:0] sum_in;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       sub_out;
  logic [4:0] result;
  logic       neg;
  logic       res_valid;
  logic       done;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  logic [1:0] e_state;
  logic [3:0] e_a;
  logic [3:0] e_b;
  logic       e_sub;
  logic [4:0] e_res;
  logic       e_neg;
  logic       e_valid;
  logic       e_done;

  always #5 clk = ~clk;

  calc_seq_ctrl #(.SETTLE_CYC(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .sub_sw    (sub_sw),
    .key_enter (key_enter),
    .key_clear (key_clear),
    .sum_in    (sum_in),
    .a_out     (a_out),
    .b_out     (b_out),
    .sub_out   (sub_out),
    .result    (result),
    .neg       (neg),
    .res_valid (res_valid),
    .done      (done),
    .state     (state)
  );

  // Ripple adder with B inversion; top bit reports borrow when subtracting.
  logic [4:0] dp_t;
  always_comb begin
    dp_t   = {1'b0, a_out} + {1'b0, b_out ^ {4{sub_out}}} + {4'b0000, sub_out};
    sum_in = {dp_t[4] ^ sub_out, dp_t[3:0]};
  end

  function automatic logic [4:0] ref_calc(input logic [3:0] a, input logic [3:0] b,
                                          input logic s);
    int d;
    if (!s) return 5'(int'(a) + int'(b));
    d = int'(a) - int'(b);
    return {(d < 0) ? 1'b1 : 1'b0, 4'(d)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 8'(state), 8'(e_state));
    chk({tag, ".a"}, 8'(a_out), 8'(e_a));
    chk({tag, ".b"}, 8'(b_out), 8'(e_b));
    chk({tag, ".sub"}, 8'(sub_out), 8'(e_sub));
    chk({tag, ".result"}, 8'(result), 8'(e_res));
    chk({tag, ".neg"}, 8'(neg), 8'(e_neg));
    chk({tag, ".valid"}, 8'(res_valid), 8'(e_valid));
    chk({tag, ".done"}, 8'(done), 8'(e_done));
  endtask

  task automatic clear_exp();
    e_state = 2'd0; e_a = 4'd0; e_b = 4'd0; e_sub = 1'b0;
    e_res = 5'd0; e_neg = 1'b0; e_valid = 1'b0; e_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Keys rise before edge n; the resulting update lands at edge n+2.
  task automatic press(input logic ent, input logic clr, input string tag);
    key_enter = ent;
    key_clear = clr;
    tick(); check_all({tag, ".n0"});
    tick(); check_all({tag, ".n1"});
    tick();
    key_enter = 1'b0;
    key_clear = 1'b0;
  endtask

  task automatic idle2(input string tag);
    sw = 4'($urandom); sub_sw = 1'($urandom);
    tick(); check_all({tag, ".idle0"});
    tick(); check_all({tag, ".idle1"});
  endtask

  task automatic load_a(input logic [3:0] a, input string tag);
    sw = a;
    press(1'b1, 1'b0, tag);
    e_a = a; e_state = 2'd1;
    check_all({tag, ".cap"});
    idle2(tag);
  endtask

  // From LOAD_B: capture B, run EXEC, check capture and first SHOW cycle.
  task automatic load_b_exec(input logic [3:0] b, input logic s, input string tag);
    sw = b; sub_sw = s;
    press(1'b1, 1'b0, {tag, ".b"});
    e_b = b; e_sub = s; e_state = 2'd2;
    check_all({tag, ".bcap"});
    for (int k = 1; k < int'(S); k++) begin
      sw = 4'($urandom); sub_sw = 1'($urandom);
      tick(); check_all({tag, ".exec"});
    end
    tick();
    e_res = ref_calc(e_a, b, s); e_neg = s & (e_a < b);
    e_state = 2'd3; e_valid = 1'b1; e_done = 1'b1;
    check_all({tag, ".capture"});
    tick();
    e_done = 1'b0;
    check_all({tag, ".show"});
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input string tag);
    load_a(a, {tag, ".a"});
    load_b_exec(b, s, tag);
  endtask

  task automatic do_clear(input string tag);
    press(1'b0, 1'b1, tag);
    clear_exp();
    check_all({tag, ".cap"});
    idle2(tag);
  endtask

  initial begin
    rst_n = 1'b0; sw = 4'd0; sub_sw = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
    clear_exp();
    #3;
    check_all("reset");
    tick(); tick();
    check_all("reset_hold");
    rst_n = 1'b1;
    tick();
    check_all("post_reset");

    // Long hold yields a single enter event.
    sw = 4'd5;
    key_enter = 1'b1;
    tick(); check_all("hold.n0");
    tick(); check_all("hold.n1");
    tick();
    e_a = 4'd5; e_state = 2'd1;
    check_all("hold.cap");
    for (int k = 0; k < 7; k++) begin
      sw = 4'($urandom);
      tick(); check_all("hold.steady");
    end
    key_enter = 1'b0;
    idle2("hold.rel");

    do_clear("clr_loadb");

    run_op(4'd9, 4'd6, 1'b0, "add96");
    chk("add96.const", 8'(result), 8'h0f);
    do_clear("clr_show");
    run_op(4'd3, 4'd7, 1'b1, "sub37");
    chk("sub37.const", 8'(result), 8'h1c);
    chk("sub37.neg", 8'(neg), 8'h01);
    do_clear("clr1");
    run_op(4'd7, 4'd3, 1'b1, "sub73");
    chk("sub73.const", 8'(result), 8'h04);
    do_clear("clr2");

    // Enter and clear together in LOAD_B: clear wins, B not captured.
    load_a(4'($urandom_range(1, 15)), "both.a");
    sw = 4'($urandom_range(1, 15)); sub_sw = 1'b1;
    press(1'b1, 1'b1, "both");
    clear_exp();
    check_all("both.cap");
    idle2("both");

    // Enter in SHOW.
    run_op(4'd4, 4'd5, 1'b0, "chain");
    press(1'b1, 1'b0, "show_enter");
    e_valid = 1'b0;
`ifdef CALC_ACCUM_EN
    e_a = e_res[3:0]; e_state = 2'd1;
    check_all("show_enter.cap");
    chk("show_enter.a9", 8'(a_out), 8'h09);
    idle2("show_enter");
    load_b_exec(4'd2, 1'b0, "accum");
    chk("accum.res11", 8'(result), 8'h0b);
`else
    e_state = 2'd0;
    check_all("show_enter.cap");
    chk("show_enter.a4", 8'(a_out), 8'h04);
    idle2("show_enter");
`endif
    do_clear("clr3");

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 10; i++) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom), "rand");
      do_clear("rand.clr");
    end

    // Reset asserted mid-EXEC aborts without capture.
    load_a(4'd8, "rst.a");
    sw = 4'd3; sub_sw = 1'b1;
    press(1'b1, 1'b0, "rst.b");
    e_b = 4'd3; e_sub = 1'b1; e_state = 2'd2;
    check_all("rst.bcap");
    tick(); check_all("rst.exec");
    #2;
    rst_n = 1'b0;
    #1;
    clear_exp();
    check_all("rst.async");
    for (int k = 0; k < int'(S) + 1; k++) begin
      tick(); check_all("rst.held");
    end
    rst_n = 1'b1;
    tick(); check_all("rst.release");
    load_a(4'd11, "rst.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Sequencing controller for the 4-bit add/subtract datapath (ripple adder plus 7-segment display path). It takes operands from four slide switches under pushbutton control and drives the datapath operands and the subtract select. It waits one cycle for the ripple chain to settle, then registers the 5-bit result so the display stays stable between operations. It sits between the board switches/keys and the adder/decoder pair in the calculator top level.

## Interface
Parameters:
- SETTLE_CYC, default 1: cycles spent in EXEC before the result is captured. Legal range is 1..7.

Ports:
- clk  in  1: system clock. All state changes on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- sw  in  4: operand switches. Asynchronous to clk; only sampled on an enter event.
- sub_sw  in  1: operation select. 0 = add, 1 = subtract. Sampled with B.
- key_enter  in  1: raw enter button, active-high, asynchronous.
- key_clear  in  1: raw clear button, active-high, asynchronous.
- sum_in  in  5: datapath result, {carry/sign, s3..s0}.
- a_out  out  4: operand A to the datapath.
- b_out  out  4: operand B to the datapath. Uninverted; the datapath XORs it with sub_out.
- sub_out  out  1: subtract select to the datapath (carry-in and B inversion).
- result  out  5: registered result, held until the next capture or clear.
- neg  out  1: registered; set when sub_out=1 and sum_in[4]=1 at capture (A<B).
- res_valid  out  1: high while in SHOW.
- done  out  1: one-cycle pulse on the capture cycle.
- state  out  2: current state. 0=LOAD_A, 1=LOAD_B, 2=EXEC, 3=SHOW.

## Operation
- Key conditioning:
  - key_enter and key_clear each pass through a 2-flop synchronizer and a rising-edge detector.
  - Each press yields exactly one enter_p/clear_p pulse, regardless of hold length.
- FSM transitions:
  - LOAD_A: on enter_p, A <= sw, then go to LOAD_B.
  - LOAD_B: on enter_p, B <= sw and sub_out <= sub_sw, then go to EXEC.
  - EXEC: load a settle counter with SETTLE_CYC. After SETTLE_CYC cycles in EXEC:
    - result <= sum_in and neg <= sub_out & sum_in[4];
    - done=1 for that cycle;
    - go to SHOW.
  - SHOW: res_valid=1; on enter_p, go to LOAD_A (see Configuration).
- a_out, b_out and sub_out are registered and change only at the capture points above. The datapath sees stable operands for the whole of EXEC.
- clear_p from any state:
  - go to LOAD_A;
  - A, B, sub_out, result, neg <= 0;
  - res_valid=0, done=0.
- clear_p and enter_p in the same cycle: clear wins and the enter is dropped.
- enter_p in EXEC is ignored (no queuing).
- sw and sub_sw changes outside a capture cycle have no effect.
- Arithmetic is owned by the datapath. The controller never modifies sum_in bits; result is a verbatim 5-bit copy.

## Timing
- Reset: state=LOAD_A; a_out=b_out=0; sub_out=0; result=0; neg=0; res_valid=0; done=0; synchronizers=0.
- Reset asserted mid-EXEC aborts the operation with no capture. On release the FSM starts in LOAD_A.
- Key latency:
  - Button high before rising edge n ⇒ edge pulse during cycle n+2.
  - The state or register update lands at edge n+2.
- EXEC latency: exactly SETTLE_CYC cycles from entering EXEC to entering SHOW. The done pulse is coincident with the last EXEC cycle's capture edge.
- Total operation, from the B-enter edge to res_valid=1: SETTLE_CYC+1 edges.
- Two presses must be separated by at least one sampled-low cycle to register as two events.

## Configuration
- CALC_ACCUM_EN defined (accumulator mode):
  - In SHOW, enter_p sets A <= result[3:0] and goes straight to LOAD_B, so operations chain on the previous result.
  - neg and result[4] are discarded on the chain.
- CALC_ACCUM_EN undefined: in SHOW, enter_p goes to LOAD_A with A unchanged until the next capture.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then hold key_enter for 10 cycles in LOAD_A with sw=5 → a_out=5, state=1, exactly one transition.
- sw=9 enter, sw=6 enter with sub_sw=0, sum_in tied to a model adder → after SETTLE_CYC+1 edges: result=5'b01111, neg=0, res_valid=1, done high for 1 cycle.
- Subtract 3−7 (sub_sw=1), model datapath → result=5'b11100, neg=1; repeat with 7−3 → result=5'b00100, neg=0.
- Enter and clear pulses in the same cycle while in LOAD_B → state=0, all outputs 0, B not captured.
- Assert rst_n=0 mid-EXEC with SETTLE_CYC=4 → immediate zero outputs, no done pulse; after release, enter captures into A.
- Build with CALC_ACCUM_EN, compute 4+5, then press enter in SHOW → a_out=9, state=1; next B=2 gives result=11.
